sar_serial_tx: RTL and testbench

//  Serial result transmitter for the SAR ADC digital back-end. Accepts one WIDTH-bit

---
 rtl/sar_serial_tx.sv | 156 +++++++++++++++
 tb/tb_sar_serial_tx.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sar_serial_tx.sv
// sar_serial_tx: serial result transmitter for the SAR ADC back-end.
// Takes one WIDTH-bit word over VALID/READY and shifts it out MSB first on a
// mode-0 link (CSN, SCLK, SDO). SCLK period is 2*DIV clock cycles.
// Optional feature macro: SAR_TX_PARITY_EN appends an even-parity bit after
// the LSB (XOR of all data bits), making the frame WIDTH+1 bits long.
module sar_serial_tx #(
  parameter int WIDTH = 10,
  parameter int DIV   = 2
) (
  input  logic             CK,
  input  logic             R,
  input  logic [WIDTH-1:0] DATA,
  input  logic             VALID,
  output logic             READY,
  output logic             BUSY,
  output logic             CSN,
  output logic             SCLK,
  output logic             SDO
);

`ifdef SAR_TX_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = $clog2(NBITS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LO   = 2'd1,
    S_HI   = 2'd2,
    S_HOLD = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [DW-1:0]    div_q, div_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [NBITS-1:0] sreg_q, sreg_d;
  logic             csn_q, csn_d;
  logic             sclk_q, sclk_d;
  logic             sdo_q, sdo_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;

  logic [NBITS-1:0] load_word;
  logic             div_last;
  logic             bit_last;

  // Frame image loaded on handshake: the word, plus its parity bit when enabled.
`ifdef SAR_TX_PARITY_EN
  assign load_word = {DATA, ^DATA};
`else
  assign load_word = DATA;
`endif

  assign div_last = (div_q == DW'(DIV - 1));
  assign bit_last = (bit_q == BW'(NBITS - 1));

  // Next-state and next-output logic; every output is taken from a flop.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d = state_q;
    div_d   = div_last ? '0 : div_q + 1'b1;
    bit_d   = bit_q;
    sreg_d  = sreg_q;
    csn_d   = csn_q;
    sclk_d  = sclk_q;
    sdo_d   = sdo_q;
    ready_d = ready_q;

    unique case (state_q)
      S_IDLE: begin
        div_d = '0;
        if (VALID && ready_q) begin
          sreg_d  = load_word;
          sdo_d   = load_word[NBITS-1];
          csn_d   = 1'b0;
          ready_d = 1'b0;
          bit_d   = '0;
          state_d = S_LO;
        end
      end
      S_LO: begin
        if (div_last) begin
          sclk_d  = 1'b1;
          div_d   = '0;
          state_d = S_HI;
        end
      end
      S_HI: begin
        if (div_last) begin
          sclk_d = 1'b0;
          div_d  = '0;
          if (!bit_last) begin
            // Next bit goes out on the falling edge, half a period before it is sampled.
            sreg_d  = sreg_q << 1;
            sdo_d   = sreg_q[NBITS-2];
            bit_d   = bit_q + 1'b1;
            state_d = S_LO;
          end else begin
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (div_last) begin
          csn_d   = 1'b1;
          sdo_d   = 1'b0;
          ready_d = 1'b1;
          div_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = ~ready_d;
  end

  // State and output registers with synchronous reset that overrides all inputs.
  always_ff @(posedge CK) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (R) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      sreg_q  <= '0;
      csn_q   <= 1'b1;
      sclk_q  <= 1'b0;
      sdo_q   <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sreg_q  <= sreg_d;
      csn_q   <= csn_d;
      sclk_q  <= sclk_d;
      sdo_q   <= sdo_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign READY = ready_q;
  assign BUSY  = busy_q;
  assign CSN   = csn_q;
  assign SCLK  = sclk_q;
  assign SDO   = sdo_q;

endmodule

// File: tb/tb_sar_serial_tx.sv
// tb_sar_serial_tx: scoreboard bench for sar_serial_tx. Accepted words push the
// expected serial frame into a queue; a monitor decodes CSN/SCLK/SDO and compares.
module tb_sar_serial_tx;

  localparam int WIDTH = 10;
  localparam int DIV   = 2;
`ifdef SAR_TX_PARITY_EN
  localparam int NB = WIDTH + 1;
`else
  localparam int NB = WIDTH;
`endif
  localparam int EXP_LOW = NB * 2 * DIV + DIV;

  logic             CK = 1'b0;
  logic             R = 1'b1;
  logic [WIDTH-1:0] DATA = '0;
  logic             VALID = 1'b0;
  logic             READY, BUSY, CSN, SCLK, SDO;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic [31:0] bits;
    int          gap;
  } exp_t;

  exp_t sb[$];
  bit   abort_pending = 1'b0;

  sar_serial_tx #(.WIDTH(WIDTH), .DIV(DIV)) dut (
    .CK(CK), .R(R), .DATA(DATA), .VALID(VALID),
    .READY(READY), .BUSY(BUSY), .CSN(CSN), .SCLK(SCLK), .SDO(SDO)
  );

  always #5 CK = ~CK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic bound_ok(input string name, input bit ok);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: wait bound expired, got timeout expected event at %0t", name, $time);
  endtask

  // Reference frame: bits in wire order, first-sent bit most significant.
  function automatic logic [31:0] ref_bits(input logic [WIDTH-1:0] w);
    logic [31:0] v;
    v = 0;
    for (int i = WIDTH - 1; i >= 0; i--) v = v * 2 + 32'(w[i]);
`ifdef SAR_TX_PARITY_EN
    v = v * 2 + 32'($countones(w) % 2);
`endif
    return v;
  endfunction

  // ---------------- monitor ----------------
  logic        m_prev_csn = 1'b1;
  logic        m_prev_sclk = 1'b0;
  int          m_low, m_high, m_rises;
  logic [31:0] m_got;
  bit          m_in_frame = 1'b0;
  bit          m_cur_ok = 1'b0;
  bit          m_hs_bad;
  exp_t        m_cur;

  initial begin
    m_low = 0; m_high = 0; m_rises = 0; m_got = 0; m_hs_bad = 0;
    forever begin
      @(negedge CK);
      if (CSN === 1'b0 && m_prev_csn === 1'b1) begin
        m_in_frame = 1'b1;
        m_low = 0; m_rises = 0; m_got = 0; m_hs_bad = 1'b0;
        n_checks++;
        if (sb.size() > 0) begin
          n_pass++;
          m_cur = sb.pop_front();
          m_cur_ok = 1'b1;
          if (m_cur.gap >= 0) check("csn_gap", m_high, m_cur.gap);
        end else begin
          m_cur_ok = 1'b0;
          $display("FAIL unexpected_frame: got CSN fall expected no frame at %0t", $time);
        end
      end
      if (m_in_frame && CSN === 1'b0) begin
        m_low++;
        if (READY !== 1'b0 || BUSY !== 1'b1) m_hs_bad = 1'b1;
        if (SCLK === 1'b1 && m_prev_sclk === 1'b0) begin
          m_rises++;
          m_got = {m_got[30:0], SDO};
        end
      end
      if (m_in_frame && CSN === 1'b1) begin
        m_in_frame = 1'b0;
        m_high = 0;
        if (abort_pending) begin
          abort_pending = 1'b0;
          check("abort_rises", m_rises, 5);
        end else if (m_cur_ok) begin
          check("frame_bits", m_got, m_cur.bits);
          check("sclk_rises", m_rises, NB);
          check("csn_low_cycles", m_low, EXP_LOW);
          check("ready_busy_in_frame", 32'(m_hs_bad), 0);
          check("ready_at_csn_rise", {READY, BUSY}, 2'b10);
        end
      end
      if (!m_in_frame && CSN === 1'b1) m_high++;
      m_prev_csn  = CSN;
      m_prev_sclk = SCLK;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic send(input logic [WIDTH-1:0] w, input int gap);
    int t;
    t = 0;
    while (READY !== 1'b1 && t < 200) begin tick(); t++; end
    bound_ok("send_ready_wait", t < 200);
    DATA  = w;
    VALID = 1'b1;
    sb.push_back('{ref_bits(w), gap});
    tick();
    VALID = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((sb.size() != 0 || READY !== 1'b1) && t < 500) begin tick(); t++; end
    bound_ok("idle_wait", t < 500);
    tick();
    tick();
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {CSN, SCLK, SDO, READY, BUSY}, 5'b10010);
  endtask

  initial begin
    int t, r;
    logic prev;
    logic [WIDTH-1:0] w;

    // Reset held with VALID asserted: no capture, reset outputs every cycle.
    R = 1'b1; VALID = 1'b1; DATA = 10'h2A5;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_reset_outputs("reset_outputs");
    end
    R = 1'b0; VALID = 1'b0;
    repeat (5) tick();
    check("no_frame_after_reset", {CSN, READY}, 2'b11);

    // Single word.
    send(10'h2A5, -1);
    wait_idle();

    // VALID held: two frames with a one-cycle CSN-high gap.
    DATA = 10'h3FF; VALID = 1'b1;
    sb.push_back('{ref_bits(10'h3FF), -1});
    t = 0;
    do begin tick(); t++; end while (BUSY !== 1'b1 && t < 20);
    bound_ok("b2b_first_accept", t < 20);
    DATA = 10'h000;
    sb.push_back('{ref_bits(10'h000), 1});
    t = 0;
    while (READY !== 1'b1 && t < 200) begin tick(); t++; end
    bound_ok("b2b_ready_wait", t < 200);
    tick();
    check("b2b_second_accept", {BUSY, READY}, 2'b10);
    VALID = 1'b0;
    wait_idle();

    // VALID pulse and DATA change mid-frame are ignored.
    send(10'h2A5, -1);
    repeat (10) tick();
    DATA = 10'h155; VALID = 1'b1;
    tick();
    VALID = 1'b0;
    check("ready_low_midframe", READY, 0);
    wait_idle();
    repeat (10) tick();
    check("no_extra_frame", CSN, 1);

    // Reset after the 5th SCLK rise aborts the frame; next frame is complete.
    send(10'h2A5, -1);
    r = 0; t = 0; prev = SCLK;
    while (r < 5 && t < 200) begin
      tick(); t++;
      if (SCLK === 1'b1 && prev === 1'b0) r++;
      prev = SCLK;
    end
    bound_ok("abort_sclk_wait", t < 200);
    abort_pending = 1'b1;
    R = 1'b1;
    tick();
    check_reset_outputs("abort_reset_outputs");
    R = 1'b0;
    tick();
    send(10'h155, -1);
    wait_idle();

    // Parity contrast word (parity 0) and boundary words.
    send(10'h003, -1);
    wait_idle();
    send(10'h001, -1);
    send(10'h200, -1);
    wait_idle();

    // Randomized words with random mid-frame noise and idle gaps.
    for (int k = 0; k < 24; k++) begin
      w = WIDTH'($urandom);
      send(w, -1);
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 30)) tick();
        if (BUSY === 1'b1) begin
          DATA = WIDTH'($urandom); VALID = 1'b1;
          tick();
          VALID = 1'b0;
        end
      end
      if ($urandom_range(0, 2) != 0) wait_idle();
      repeat ($urandom_range(0, 3)) tick();
    end
    wait_idle();

    repeat (5) tick();
    check("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
